class_argmax: RTL and testbench
===============================

CLASS_ARGMAX -- requirements
Module: class_argmax

Interface
REQ-001 Parameter WIDTH, default 32: bit width of the signed partial-sum input and of the per-class score.
REQ-002 Parameter NUM_CLASSES, default 6: number of output classes (nodes), legal range 2..64.
REQ-003 Parameter IDX_W, default $clog2(NUM_CLASSES): width of the class index.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 clear  in  1  synchronous soft clear; restarts a new classification.
REQ-007 sum  in  WIDTH  signed partial sum for the current class.
REQ-008 accumulate_en  in  1  add sum into the current class accumulator this cycle.
REQ-009 store_en  in  1  commit the current accumulator as the score of the current class.
REQ-010 detection_out  out  WIDTH  winning class index, zero-extended from IDX_W.
REQ-011 max_score  out  WIDTH  signed score of the winning class.
REQ-012 out_valid  out  1  high while detection_out and max_score hold a completed result.
REQ-013 class_idx  out  IDX_W  index of the class currently being accumulated.
REQ-014 overflow  out  1  sticky flag: a saturation or a protocol error occurred since the last clear or reset.

Function
REQ-015 The FSM SHALL have two states: COLLECT and DONE.
REQ-016 In COLLECT, accumulate_en=1 with store_en=0 SHALL set acc <= sat(acc + sum), where sat clamps to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1]; clamping sets overflow.
REQ-017 In COLLECT, store_en=1 SHALL commit the score s = sat(acc + (accumulate_en ? sum : 0)), clear acc to 0, and increment class_idx.
  - The simultaneous accumulate_en and store_en case is covered by this rule.
REQ-018 On commit of class 0, s SHALL be loaded unconditionally as the running max with index 0.
REQ-019 On commit of class k>0, the running max and its index SHALL be replaced only if s > running max (strict signed compare).
  - Ties keep the lowest index.
REQ-020 The commit of class NUM_CLASSES-1 SHALL include that class in the compare and move the FSM to DONE.
  - In the same edge it SHALL update detection_out and max_score and set out_valid.
  - The final result is therefore visible one cycle after the sampling of the final store_en.
REQ-021 In DONE, outputs SHALL hold and accumulate_en SHALL be ignored.
REQ-022 In DONE, any store_en SHALL be ignored for data and SHALL set overflow.
REQ-023 clear=1 in either state SHALL set acc=0, class_idx=0, running max=0, out_valid=0, overflow=0 and state=COLLECT, and clear has priority over all other inputs that cycle.
  - detection_out and max_score SHALL keep their last values until the next completed classification.
REQ-024 accumulate_en and store_en both low SHALL leave all state unchanged, for any number of idle cycles.
REQ-025 The running-max compare SHALL be performed on WIDTH-bit signed values only; no wider score storage is required.

Reset
REQ-026 While rst=1, the block SHALL immediately, independent of clk, force state=COLLECT, acc=0, class_idx=0, running max=0, detection_out=0, max_score=0, out_valid=0 and overflow=0.
REQ-027 rst asserted mid-classification SHALL discard all partial results, and no out_valid pulse SHALL follow.
REQ-028 After rst deasserts, the first rising edge SHALL already accept accumulate_en and store_en.

Verification (NUM_CLASSES=6, WIDTH=32)
REQ-029 The bench SHALL cover basic argmax.
  - Stimulus: 3 sums per class, class sums (10, -5, 42, 7, 0, 41).
  - Required response: detection_out=2, max_score=42, out_valid=1 one cycle after the 6th store_en.
REQ-030 The bench SHALL cover a tie.
  - Stimulus: class scores (3, 9, 9, 1, 9, 0).
  - Required response: detection_out=1, max_score=9.
REQ-031 The bench SHALL cover all-negative scores.
  - Stimulus: class scores (-100, -7, -50, -8, -2^31, -9).
  - Required response: detection_out=1, max_score=-7.
REQ-032 The bench SHALL cover saturation.
  - Stimulus: class 0 gets sums 2^31-1 then 5; other classes get 0.
  - Required response: max_score=2147483647, detection_out=0, overflow=1.
REQ-033 The bench SHALL cover simultaneous enables and an extra store.
  - Stimulus: per class, sums 1 and 2 with accumulate_en only, then 4 with accumulate_en and store_en together.
  - Required response: every score is 7, detection_out=0; a 7th store_en in DONE sets overflow=1 and leaves outputs unchanged.
REQ-034 The bench SHALL cover mid-operation reset and clear.
  - Stimulus: rst pulse after 3 commits, then a full run of (1, 2, 3, 4, 5, 6).
  - Required response: detection_out=5 with no earlier out_valid.
  - Stimulus: a following clear.
  - Required response: out_valid=0, class_idx=0, detection_out stays 5.

Source files
------------

// File: rtl/class_argmax_if.sv
// class_argmax_if: classification stream in, argmax result out.
interface class_argmax_if #(
    parameter int WIDTH       = 32,
    parameter int NUM_CLASSES = 6,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
);
    logic                    clear;
    logic signed [WIDTH-1:0] sum;
    logic                    accumulate_en;
    logic                    store_en;
    logic        [WIDTH-1:0] detection_out;
    logic signed [WIDTH-1:0] max_score;
    logic                    out_valid;
    logic        [IDX_W-1:0] class_idx;
    logic                    overflow;

    modport master (
        output clear, sum, accumulate_en, store_en,
        input  detection_out, max_score, out_valid, class_idx, overflow
    );

    modport slave (
        input  clear, sum, accumulate_en, store_en,
        output detection_out, max_score, out_valid, class_idx, overflow
    );
endinterface

// File: rtl/class_argmax.sv
// class_argmax: accumulates per-class signed partial sums with saturation
// and reports the index and score of the highest class (ties keep lowest index).
module class_argmax #(
    parameter int WIDTH       = 32,
    parameter int NUM_CLASSES = 6,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input logic          clk,
    input logic          rst,
    class_argmax_if.slave bus
);
    typedef enum logic {COLLECT, DONE} state_t;

    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                  state, state_nx;
    logic signed [WIDTH-1:0] acc, run_max, addend, sat_sum, new_max;
    logic signed [WIDTH:0]   wide;
    logic        [IDX_W-1:0] class_idx, run_idx, new_idx;
    logic        [WIDTH-1:0] detection_out;
    logic signed [WIDTH-1:0] max_score;
    logic                    out_valid, overflow;
    logic                    sat, last, take, do_acc, do_store, bad_store;

    // One extra bit exposes signed overflow of acc + addend for clamping.
    always_comb begin
        addend    = bus.accumulate_en ? bus.sum : '0;
        wide      = {acc[WIDTH-1], acc} + {addend[WIDTH-1], addend};
        sat       = wide[WIDTH] ^ wide[WIDTH-1];
        sat_sum   = sat ? (wide[WIDTH] ? S_MIN : S_MAX) : wide[WIDTH-1:0];
        last      = class_idx == IDX_W'(NUM_CLASSES - 1);
        take      = class_idx == '0 || sat_sum > run_max;
        new_max   = take ? sat_sum : run_max;
        new_idx   = take ? class_idx : run_idx;
        do_store  = state == COLLECT && bus.store_en;
        do_acc    = state == COLLECT && bus.accumulate_en && !bus.store_en;
        bad_store = state == DONE && bus.store_en;
        state_nx  = bus.clear ? COLLECT : (do_store && last) ? DONE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= COLLECT;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc           <= '0;
            class_idx     <= '0;
            run_max       <= '0;
            run_idx       <= '0;
            detection_out <= '0;
            max_score     <= '0;
            out_valid     <= 1'b0;
            overflow      <= 1'b0;
        end else if (bus.clear) begin
            acc       <= '0;
            class_idx <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= overflow | ((do_acc || do_store) && sat) | bad_store;
            if (do_acc)
                acc <= sat_sum;
            if (do_store) begin
                acc       <= '0;
                class_idx <= class_idx + 1'b1;
                run_max   <= new_max;
                run_idx   <= new_idx;
                if (last) begin
                    detection_out <= WIDTH'(new_idx);
                    max_score     <= new_max;
                    out_valid     <= 1'b1;
                end
            end
        end
    end

    assign bus.detection_out = detection_out;
    assign bus.max_score     = max_score;
    assign bus.out_valid     = out_valid;
    assign bus.class_idx     = class_idx;
    assign bus.overflow      = overflow;
endmodule

// File: tb/tb_class_argmax.sv
// tb_class_argmax: table-driven argmax runs plus directed reset/clear/extra-store sequences.
module tb_class_argmax;
    localparam int W = 32;
    localparam int N = 6;

    typedef logic [2:0][W-1:0] cls_t;
    typedef logic [5:0][2:0][W-1:0] row_t;
    typedef struct packed {
        row_t         s;
        logic [W-1:0] det;
        logic [W-1:0] mx;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   passed = 0;
    vec_t tbl[5];

    always #5 clk = ~clk;

    class_argmax_if #(.WIDTH(W), .NUM_CLASSES(N)) bus ();
    class_argmax #(.WIDTH(W), .NUM_CLASSES(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    function automatic cls_t t3(input logic [W-1:0] a, b, c);
        return {c, b, a};
    endfunction

    function automatic row_t row(input cls_t k0, k1, k2, k3, k4, k5);
        return {k5, k4, k3, k2, k1, k0};
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc(input logic clr, ae, se, input logic [W-1:0] s);
        @(negedge clk);
        bus.clear = clr;
        bus.accumulate_en = ae;
        bus.store_en = se;
        bus.sum = s;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        bus.accumulate_en = 1'b0;
        bus.store_en = 1'b0;
        bus.sum = '0;
    endtask

    initial begin
        tbl[0] = '{s: row(t3(4, 3, 3), t3(-2, -2, -1), t3(20, 20, 2), t3(1, 2, 4), t3(5, -5, 0), t3(40, 0, 1)),
                   det: 2, mx: 42, ovf: 1'b0};
        tbl[1] = '{s: row(t3(3, 0, 0), t3(9, 0, 0), t3(9, 0, 0), t3(1, 0, 0), t3(9, 0, 0), t3(0, 0, 0)),
                   det: 1, mx: 9, ovf: 1'b0};
        tbl[2] = '{s: row(t3(-100, 0, 0), t3(-7, 0, 0), t3(-50, 0, 0), t3(-8, 0, 0), t3(32'h8000_0000, 0, 0), t3(-9, 0, 0)),
                   det: 1, mx: -7, ovf: 1'b0};
        tbl[3] = '{s: row(t3(32'h7fff_ffff, 5, 0), t3(0, 0, 0), t3(0, 0, 0), t3(0, 0, 0), t3(0, 0, 0), t3(0, 0, 0)),
                   det: 0, mx: 32'h7fff_ffff, ovf: 1'b1};
        tbl[4] = '{s: row(t3(1, 2, 4), t3(1, 2, 4), t3(1, 2, 4), t3(1, 2, 4), t3(1, 2, 4), t3(1, 2, 4)),
                   det: 0, mx: 7, ovf: 1'b0};

        rst = 1'b1;
        bus.clear = 1'b0;
        bus.accumulate_en = 1'b0;
        bus.store_en = 1'b0;
        bus.sum = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset det", bus.detection_out, 0);
        chk("reset max", bus.max_score, 0);
        chk("reset valid", W'(bus.out_valid), 0);
        chk("reset idx", W'(bus.class_idx), 0);
        chk("reset ovf", W'(bus.overflow), 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            cyc(1'b1, 1'b0, 1'b0, 0);
            for (int k = 0; k < N; k++) begin
                cyc(1'b0, 1'b1, 1'b0, tbl[v].s[k][0]);
                cyc(1'b0, 1'b1, 1'b0, tbl[v].s[k][1]);
                if (k == N - 1)
                    chk($sformatf("v%0d early valid", v), W'(bus.out_valid), 0);
                cyc(1'b0, 1'b1, 1'b1, tbl[v].s[k][2]);
            end
            chk($sformatf("v%0d det", v), bus.detection_out, tbl[v].det);
            chk($sformatf("v%0d max", v), bus.max_score, tbl[v].mx);
            chk($sformatf("v%0d valid", v), W'(bus.out_valid), 1);
            chk($sformatf("v%0d ovf", v), W'(bus.overflow), W'(tbl[v].ovf));
        end

        // Extra store (with accumulate) while DONE: flags overflow, data untouched.
        cyc(1'b0, 1'b1, 1'b1, 100);
        chk("extra ovf", W'(bus.overflow), 1);
        chk("extra det", bus.detection_out, 0);
        chk("extra max", bus.max_score, 7);
        chk("extra valid", W'(bus.out_valid), 1);

        cyc(1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b1, 1'b1, 50 + k);
        chk("pre-rst idx", W'(bus.class_idx), 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst idx", W'(bus.class_idx), 0);
        chk("async rst max", bus.max_score, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            cyc(1'b0, 1'b1, 1'b1, k + 1);
            if (k < N - 1)
                chk($sformatf("run valid k%0d", k), W'(bus.out_valid), 0);
            cyc(1'b0, 1'b0, 1'b0, 0);
            chk($sformatf("idle idx k%0d", k), W'(bus.class_idx), k + 1);
        end
        chk("run det", bus.detection_out, 5);
        chk("run max", bus.max_score, 6);
        chk("run valid", W'(bus.out_valid), 1);

        // Clear wins over simultaneous enables.
        cyc(1'b1, 1'b1, 1'b1, 99);
        chk("clear valid", W'(bus.out_valid), 0);
        chk("clear idx", W'(bus.class_idx), 0);
        chk("clear det", bus.detection_out, 5);
        chk("clear max", bus.max_score, 6);
        chk("clear ovf", W'(bus.overflow), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
